// File: rtl/alu_issue_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_unit
// Purpose  : Issue/writeback front-end for an external combinational ALU.
//            Owns an 8-entry register file, accepts one operation per
//            valid/ready handshake, holds ALU operands/opcode stable for
//            SETTLE_CYCLES full cycles, then writes RESULT back to the
//            destination register and pulses a completion response.
// Ports    : CLK, RESET              clock / asynchronous active-high reset
//            REQ_VALID, REQ_READY    request handshake
//            REQ_SELECT/SRC1/SRC2/IMM/USE_IMM/DEST  request fields
//            DATA1, DATA2, SELECT    registered ALU inputs
//            RESULT                  ALU output
//            RSP_VALID/RESULT/DEST   completion pulse and captured result
//            DBG_ADDR, DBG_DATA      combinational register file read port
// Revision : 1.0  initial release
// ============================================================================
module alu_issue_unit #(
  parameter int DATA_WIDTH    = 8,
  parameter int REG_COUNT     = 8,
  parameter int SETTLE_CYCLES = 2   // legal range 1..15
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic [2:0]            REQ_SELECT,
  input  logic [2:0]            REQ_SRC1,
  input  logic [2:0]            REQ_SRC2,
  input  logic [DATA_WIDTH-1:0] REQ_IMM,
  input  logic                  REQ_USE_IMM,
  input  logic [2:0]            REQ_DEST,
  output logic [DATA_WIDTH-1:0] DATA1,
  output logic [DATA_WIDTH-1:0] DATA2,
  output logic [2:0]            SELECT,
  input  logic [DATA_WIDTH-1:0] RESULT,
  output logic                  RSP_VALID,
  output logic [DATA_WIDTH-1:0] RSP_RESULT,
  output logic [2:0]            RSP_DEST,
  input  logic [2:0]            DBG_ADDR,
  output logic [DATA_WIDTH-1:0] DBG_DATA
);

  localparam int              c_ADDR_W   = 3;
  localparam logic [0:0]      c_IDLE     = 1'b0;
  localparam logic [0:0]      c_EXEC     = 1'b1;
  // Counter is loaded with SETTLE_CYCLES-1 so that the writeback edge is
  // exactly SETTLE_CYCLES edges after the accept edge.
  localparam logic [3:0]      c_CNT_INIT = 4'(SETTLE_CYCLES - 1);

  logic [0:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  w_accept;
  logic                  w_wb;

  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] data1_q, data2_q;
  logic [2:0]            select_q;
  logic [c_ADDR_W-1:0]   dest_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_result_q;
  logic [c_ADDR_W-1:0]   rsp_dest_q;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= c_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    w_accept = 1'b0;
    w_wb     = 1'b0;
    case (state_q)
      c_IDLE: begin
        if (REQ_VALID) begin
          w_accept = 1'b1;
          cnt_d    = c_CNT_INIT;
          state_d  = c_EXEC;
        end
      end
      c_EXEC: begin
        // Request inputs are deliberately ignored here; REQ_VALID may stay
        // high and will be taken once the unit is back in IDLE.
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          w_wb    = 1'b1;
          state_d = c_IDLE;
        end
      end
      default: begin
        state_d = c_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (ready depends on state only, no path from REQ_VALID)
  // --------------------------------------------------------------------------
  always_comb begin
    REQ_READY = (state_q == c_IDLE);
  end

  // --------------------------------------------------------------------------
  // Issue and response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      data1_q      <= '0;
      data2_q      <= '0;
      select_q     <= 3'd0;
      dest_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_dest_q   <= '0;
    end else begin
      // Operands are read from the register file at the accept edge; any
      // earlier writeback has already landed, so no bypass is required.
      if (w_accept) begin
        data1_q  <= regs_q[REQ_SRC1];
        data2_q  <= REQ_USE_IMM ? REQ_IMM : regs_q[REQ_SRC2];
        select_q <= REQ_SELECT;
        dest_q   <= REQ_DEST;
      end
      rsp_valid_q <= w_wb;
      if (w_wb) begin
        rsp_result_q <= RESULT;
        rsp_dest_q   <= dest_q;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Register file: one register per entry, written verbatim with RESULT
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < REG_COUNT; g++) begin : g_regfile
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        regs_q[g] <= '0;
      end else if (w_wb && (dest_q == c_ADDR_W'(g))) begin
        regs_q[g] <= RESULT;
      end
    end
  end

  assign DATA1      = data1_q;
  assign DATA2      = data2_q;
  assign SELECT     = select_q;
  assign RSP_VALID  = rsp_valid_q;
  assign RSP_RESULT = rsp_result_q;
  assign RSP_DEST   = rsp_dest_q;
  assign DBG_DATA   = regs_q[DBG_ADDR];

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_unit
// Purpose  : Self-checking bench for alu_issue_unit. Two instances share the
//            request bus: unit A with the default settle window of 2, unit B
//            with a settle window of 1. Each has its own ALU model, valid
//            line, expected-response queue and register model.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_issue_unit;

  typedef struct {
    logic [2:0] dest;
    logic [7:0] res;
    int         acc;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [2:0] sel, src1, src2, dest, dbg_addr;
  logic [7:0] imm;
  logic       use_imm;

  logic       vld_a, rdy_a, rspv_a, vld_b, rdy_b, rspv_b;
  logic [7:0] d1_a, d2_a, res_a, rspr_a, dbg_a;
  logic [7:0] d1_b, d2_b, res_b, rspr_b, dbg_b;
  logic [2:0] selo_a, rspd_a, selo_b, rspd_b;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  logic [7:0] mdl [2][8];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Reference ALU: 0 forward b, 1 add (wraps), 2 and, 3 or, reserved -> xor
  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b,
                                     input logic [2:0] s);
    case (s)
      3'd0:    return b;
      3'd1:    return a + b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  assign res_a = alu(d1_a, d2_a, selo_a);
  assign res_b = alu(d1_b, d2_b, selo_b);

  alu_issue_unit #(.DATA_WIDTH(8), .REG_COUNT(8), .SETTLE_CYCLES(2)) u_dut_a (
    .CLK(CLK), .RESET(RESET), .REQ_VALID(vld_a), .REQ_READY(rdy_a),
    .REQ_SELECT(sel), .REQ_SRC1(src1), .REQ_SRC2(src2), .REQ_IMM(imm),
    .REQ_USE_IMM(use_imm), .REQ_DEST(dest), .DATA1(d1_a), .DATA2(d2_a),
    .SELECT(selo_a), .RESULT(res_a), .RSP_VALID(rspv_a), .RSP_RESULT(rspr_a),
    .RSP_DEST(rspd_a), .DBG_ADDR(dbg_addr), .DBG_DATA(dbg_a)
  );

  alu_issue_unit #(.DATA_WIDTH(8), .REG_COUNT(8), .SETTLE_CYCLES(1)) u_dut_b (
    .CLK(CLK), .RESET(RESET), .REQ_VALID(vld_b), .REQ_READY(rdy_b),
    .REQ_SELECT(sel), .REQ_SRC1(src1), .REQ_SRC2(src2), .REQ_IMM(imm),
    .REQ_USE_IMM(use_imm), .REQ_DEST(dest), .DATA1(d1_b), .DATA2(d2_b),
    .SELECT(selo_b), .RESULT(res_b), .RSP_VALID(rspv_b), .RSP_RESULT(rspr_b),
    .RSP_DEST(rspd_b), .DBG_ADDR(dbg_addr), .DBG_DATA(dbg_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int u);
    return (u == 0) ? rdy_a : rdy_b;
  endfunction

  // Response scoreboard: every RSP_VALID cycle must match the oldest
  // expected entry, arrive SETTLE_CYCLES edges after its accept, and a pulse
  // with nothing pending (e.g. a stretched pulse) is an error.
  always @(negedge CLK) begin
    if (rspv_a === 1'b1) begin
      if (q_a.size() == 0) chk("rsp_a_unexpected", 32'(rspv_a), 0);
      else begin
        exp_t e;
        e = q_a.pop_front();
        chk("rsp_a_result", 32'(rspr_a), 32'(e.res));
        chk("rsp_a_dest", 32'(rspd_a), 32'(e.dest));
        chk("rsp_a_latency", 32'(cyc - e.acc), 2);
      end
    end
    if (rspv_b === 1'b1) begin
      if (q_b.size() == 0) chk("rsp_b_unexpected", 32'(rspv_b), 0);
      else begin
        exp_t e;
        e = q_b.pop_front();
        chk("rsp_b_result", 32'(rspr_b), 32'(e.res));
        chk("rsp_b_dest", 32'(rspd_b), 32'(e.dest));
        chk("rsp_b_latency", 32'(cyc - e.acc), 1);
      end
    end
  end

  // Drive one request at the first negedge where the unit is ready, push its
  // expected response from the register model, return just after accept.
  task automatic issue(input int u, input logic [2:0] s, input logic [2:0] s1,
                       input logic [2:0] s2, input logic [7:0] im, input logic ui,
                       input logic [2:0] d, input bit keep, output int acc);
    int   n;
    exp_t e;
    logic [7:0] a, b;
    @(negedge CLK);
    n = 0;
    while (!rdy(u) && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!rdy(u)) begin
      chk("ready_timeout", 32'(rdy(u)), 1);
      acc = -1;
      return;
    end
    sel = s; src1 = s1; src2 = s2; imm = im; use_imm = ui; dest = d;
    if (u == 0) vld_a = 1'b1; else vld_b = 1'b1;
    a      = mdl[u][s1];
    b      = ui ? im : mdl[u][s2];
    e.dest = d;
    e.res  = alu(a, b, s);
    e.acc  = cyc + 1;
    acc    = cyc + 1;
    mdl[u][d] = e.res;
    if (u == 0) q_a.push_back(e); else q_b.push_back(e);
    @(posedge CLK);
    #1;
    if (!keep) begin
      vld_a = 1'b0;
      vld_b = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) chk("drain_timeout", 32'(q_a.size() + q_b.size()), 0);
  endtask

  task automatic dbg_chk(input int u, input logic [2:0] addr, input logic [7:0] exp);
    dbg_addr = addr;
    #1;
    chk($sformatf("dbg_u%0d_R%0d", u, addr), 32'((u == 0) ? dbg_a : dbg_b), 32'(exp));
  endtask

  task automatic ready_low_count(input int expn);
    int n;
    n = 0;
    @(negedge CLK);
    while (rdy_a == 1'b0 && n < 20) begin
      n++;
      @(negedge CLK);
    end
    chk("ready_low_cycles", 32'(n), 32'(expn));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int acc0, acc1;
    RESET = 1'b1; vld_a = 1'b0; vld_b = 1'b0;
    sel = '0; src1 = '0; src2 = '0; imm = '0; use_imm = 1'b0; dest = '0; dbg_addr = '0;
    for (int u = 0; u < 2; u++) for (int r = 0; r < 8; r++) mdl[u][r] = 8'd0;
    repeat (2) @(negedge CLK);
    chk("reset_ready", 32'(rdy_a), 1);
    chk("reset_rsp_valid", 32'(rspv_a), 0);
    chk("reset_data1", 32'(d1_a), 0);
    chk("reset_select", 32'(selo_a), 0);
    dbg_chk(0, 3'd0, 8'd0);
    @(negedge CLK);
    RESET = 1'b0;

    // Load immediates
    issue(0, 3'd0, 3'd0, 3'd0, 8'd17, 1'b1, 3'd1, 1'b0, acc0);
    issue(0, 3'd0, 3'd0, 3'd0, 8'd15, 1'b1, 3'd2, 1'b0, acc0);
    drain();
    dbg_chk(0, 3'd1, 8'd17);
    dbg_chk(0, 3'd2, 8'd15);

    // ALU ops on R1, R2 with ready-low window measurement
    issue(0, 3'd1, 3'd1, 3'd2, 8'd0, 1'b0, 3'd3, 1'b0, acc0);
    ready_low_count(2);
    issue(0, 3'd2, 3'd1, 3'd2, 8'd0, 1'b0, 3'd4, 1'b0, acc0);
    ready_low_count(2);
    issue(0, 3'd3, 3'd1, 3'd2, 8'd0, 1'b0, 3'd5, 1'b0, acc0);
    drain();
    dbg_chk(0, 3'd3, 8'd32);
    dbg_chk(0, 3'd4, 8'd1);
    dbg_chk(0, 3'd5, 8'd31);

    // Wrap-around add and back-to-back read-after-write
    issue(0, 3'd0, 3'd0, 3'd0, 8'd200, 1'b1, 3'd1, 1'b0, acc0);
    issue(0, 3'd0, 3'd0, 3'd0, 8'd100, 1'b1, 3'd2, 1'b0, acc0);
    issue(0, 3'd1, 3'd1, 3'd2, 8'd0, 1'b0, 3'd6, 1'b0, acc0);
    issue(0, 3'd2, 3'd6, 3'd0, 8'd255, 1'b1, 3'd7, 1'b0, acc1);
    chk("raw_data1", 32'(d1_a), 32'd44);
    chk("raw_accept_gap", 32'(acc1 - acc0), 3);
    drain();
    dbg_chk(0, 3'd6, 8'd44);
    dbg_chk(0, 3'd7, 8'd44);

    // Reserved opcode writes back like any other, into R0
    issue(0, 3'd5, 3'd1, 3'd0, 8'd3, 1'b1, 3'd0, 1'b0, acc0);
    drain();
    dbg_chk(0, 3'd0, 8'd203);

    // Stall: valid held high with changing fields during EXEC
    issue(0, 3'd1, 3'd3, 3'd0, 8'd1, 1'b1, 3'd2, 1'b1, acc0);
    @(negedge CLK);
    sel = 3'd0; imm = 8'd99; use_imm = 1'b1; dest = 3'd7;
    chk("stall_ready_0", 32'(rdy_a), 0);
    @(negedge CLK);
    sel = 3'd3; src1 = 3'd6; dest = 3'd6;
    chk("stall_ready_1", 32'(rdy_a), 0);
    issue(0, 3'd0, 3'd0, 3'd0, 8'd77, 1'b1, 3'd4, 1'b0, acc1);
    chk("stall_second_accept", 32'(acc1 - acc0), 3);
    drain();
    dbg_chk(0, 3'd2, 8'd33);
    dbg_chk(0, 3'd4, 8'd77);
    dbg_chk(0, 3'd7, 8'd44);
    dbg_chk(0, 3'd6, 8'd44);

    // Settle window of 1 on unit B
    issue(1, 3'd0, 3'd0, 3'd0, 8'd9, 1'b1, 3'd1, 1'b0, acc0);
    issue(1, 3'd1, 3'd1, 3'd0, 8'd1, 1'b1, 3'd2, 1'b0, acc1);
    chk("b_accept_gap", 32'(acc1 - acc0), 2);
    drain();
    dbg_chk(1, 3'd2, 8'd10);

    // Reset one cycle after accepting an add; the op must vanish
    issue(0, 3'd1, 3'd1, 3'd2, 8'd0, 1'b0, 3'd3, 1'b0, acc0);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    q_a.delete();
    q_b.delete();
    for (int u = 0; u < 2; u++) for (int r = 0; r < 8; r++) mdl[u][r] = 8'd0;
    #1;
    chk("rst_data1", 32'(d1_a), 0);
    chk("rst_data2", 32'(d2_a), 0);
    chk("rst_select", 32'(selo_a), 0);
    chk("rst_rsp_result", 32'(rspr_a), 0);
    chk("rst_rsp_dest", 32'(rspd_a), 0);
    chk("rst_rsp_valid", 32'(rspv_a), 0);
    for (int r = 0; r < 8; r++) dbg_chk(0, 3'(r), 8'd0);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    chk("rst_ready_after", 32'(rdy_a), 1);
    repeat (4) @(negedge CLK);
    issue(0, 3'd0, 3'd0, 3'd0, 8'd5, 1'b1, 3'd0, 1'b0, acc0);
    drain();
    dbg_chk(0, 3'd0, 8'd5);
    dbg_chk(0, 3'd3, 8'd0);

    repeat (5) @(negedge CLK);
    chk("queues_empty", 32'(q_a.size() + q_b.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
